// File: rtl/rvc_asap_pkg.sv
// Shared types and opcode constants for the end-of-test monitor.
package rvc_asap_pkg;

    typedef enum logic [1:0] {
        EOT_NONE    = 2'd0,
        EOT_EBREAK  = 2'd1,
        EOT_ECALL   = 2'd2,
        EOT_TIMEOUT = 2'd3
    } eot_status_t;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } eot_state_t;

    localparam logic [31:0] EBREAK_OPCODE = 32'h0010_0073;
    localparam logic [31:0] ECALL_OPCODE  = 32'h0000_0073;

endpackage

// File: rtl/rvc_asap_eot_monitor.sv
// Detects end of test (ebreak / ecall / timeout), then streams a word-by-word
// dump of the data-memory window out through a valid/ready snapshot port.
module rvc_asap_eot_monitor
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] D_MEM_OFFSET   = 32'h1000,
    parameter int          MSB_D_MEM      = 11,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter bit          ECALL_EN       = 1'b1
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        InstrValid,
    input  logic [31:0] Instruction,
    output logic        MemRdEn,
    output logic [31:0] MemRdAddr,
    input  logic [31:0] MemRdData,
    output logic        SnapValid,
    input  logic        SnapReady,
    output logic [31:0] SnapAddr,
    output logic [31:0] SnapData,
    output logic        EotDone,
    output logic [1:0]  EotStatus,
    output logic [31:0] EotCycles
);

    localparam logic [31:0] WIN_BYTES    = 32'(1) << (MSB_D_MEM + 1);
    localparam logic [31:0] LAST_ADDR    = D_MEM_OFFSET + WIN_BYTES - 32'd4;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    eot_state_t  state_q, state_d;
    eot_status_t status_q, status_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] snap_addr_q, snap_addr_d;
    logic [31:0] snap_data_q, snap_data_d;

    logic is_ebreak, is_ecall, is_timeout;

    always_comb begin
        is_ebreak  = InstrValid && (Instruction == EBREAK_OPCODE);
        is_ecall   = ECALL_EN && InstrValid && (Instruction == ECALL_OPCODE);
        is_timeout = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);
    end

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        snap_addr_d = snap_addr_q;
        snap_data_d = snap_data_q;
        case (state_q)
            ST_RUN: begin
                // The event cycle itself is not counted, so EotCycles is frozen
                // at the cycle index on which the end condition was seen.
                if (is_ebreak || is_ecall || is_timeout) begin
                    state_d = ST_RD;
                    ptr_d   = D_MEM_OFFSET;
                    if (is_ebreak)     status_d = EOT_EBREAK;
                    else if (is_ecall) status_d = EOT_ECALL;
                    else               status_d = EOT_TIMEOUT;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                snap_data_d = MemRdData;
                snap_addr_d = ptr_q;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (SnapReady) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + 32'd4;
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            status_q    <= EOT_NONE;
            cnt_q       <= 32'd0;
            ptr_q       <= 32'd0;
            snap_addr_q <= 32'd0;
            snap_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            snap_addr_q <= snap_addr_d;
            snap_data_q <= snap_data_d;
        end
    end

    assign MemRdEn   = (state_q == ST_RD);
    assign MemRdAddr = ptr_q;
    assign SnapValid = (state_q == ST_OUT);
    assign SnapAddr  = snap_addr_q;
    assign SnapData  = snap_data_q;
    assign EotDone   = (state_q == ST_DONE);
    assign EotStatus = status_q;
    assign EotCycles = cnt_q;

endmodule

// File: tb/tb_rvc_asap_eot_monitor.sv
// Randomized self-checking bench for the end-of-test monitor (4-word window).
module tb_rvc_asap_eot_monitor;
    import rvc_asap_pkg::*;

    localparam int MSB  = 3;
    localparam int NENT = 4;
    localparam int TO   = 50;

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic        InstrValid = 1'b0;
    logic [31:0] Instruction = 32'd0;
    logic        SnapReady = 1'b0;

    logic        mem_rd_en0, mem_rd_en1;
    logic [31:0] mem_rd_addr0, mem_rd_addr1;
    logic [31:0] mem_rd_data0 = 32'd0, mem_rd_data1 = 32'd0;
    logic        snap_valid0, snap_valid1;
    logic [31:0] snap_addr0, snap_addr1, snap_data0, snap_data1;
    logic        eot_done0, eot_done1;
    logic [1:0]  eot_status0, eot_status1;
    logic [31:0] eot_cycles0, eot_cycles1;

    rvc_asap_eot_monitor #(.D_MEM_OFFSET(32'h1000), .MSB_D_MEM(MSB), .TIMEOUT_CYCLES(TO), .ECALL_EN(1'b1)) dut0 (
        .Clock(Clock), .Rst(Rst), .InstrValid(InstrValid), .Instruction(Instruction),
        .MemRdEn(mem_rd_en0), .MemRdAddr(mem_rd_addr0), .MemRdData(mem_rd_data0),
        .SnapValid(snap_valid0), .SnapReady(SnapReady), .SnapAddr(snap_addr0), .SnapData(snap_data0),
        .EotDone(eot_done0), .EotStatus(eot_status0), .EotCycles(eot_cycles0));

    rvc_asap_eot_monitor #(.D_MEM_OFFSET(32'h1000), .MSB_D_MEM(MSB), .TIMEOUT_CYCLES(TO), .ECALL_EN(1'b0)) dut1 (
        .Clock(Clock), .Rst(Rst), .InstrValid(InstrValid), .Instruction(Instruction),
        .MemRdEn(mem_rd_en1), .MemRdAddr(mem_rd_addr1), .MemRdData(mem_rd_data1),
        .SnapValid(snap_valid1), .SnapReady(SnapReady), .SnapAddr(snap_addr1), .SnapData(snap_data1),
        .EotDone(eot_done1), .EotStatus(eot_status1), .EotCycles(eot_cycles1));

    always #5 Clock = ~Clock;

    logic [31:0] mem [NENT];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1000 + 32'(4 * NENT) && a[1:0] == 2'b00)
            return mem[int'((a - 32'h1000) >> 2)];
        return 32'hBAD0_0000 ^ a;
    endfunction

    // Memory answers one cycle after a read request; garbage otherwise.
    always @(posedge Clock) begin
        mem_rd_data0 <= mem_rd_en0 ? mem_rd(mem_rd_addr0) : $urandom;
        mem_rd_data1 <= mem_rd_en1 ? mem_rd(mem_rd_addr1) : $urandom;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          unstable, rd_pulses, done_cyc;
    bit          timed_out;

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Rst = 1'b1; InstrValid = 1'b0; Instruction = 32'd0; SnapReady = 1'b0;
        step; step;
        Rst = 1'b0;
    endtask

    task automatic fill_mem;
        foreach (mem[i]) mem[i] = $urandom;
    endtask

    // Non-terminating traffic, including end opcodes with InstrValid low.
    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            InstrValid  = 1'($urandom_range(0, 1));
            Instruction = $urandom | 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) begin
                InstrValid  = 1'b0;
                Instruction = ($urandom_range(0, 1) == 1) ? EBREAK_OPCODE : ECALL_OPCODE;
            end
            step;
        end
        InstrValid = 1'b0;
    endtask

    // Drives SnapReady and stray end opcodes while recording dut0's snapshot stream.
    task automatic collect(input bit rand_ready);
        logic [31:0] pa, pd;
        bit stalled;
        stalled = 1'b0; pa = 32'd0; pd = 32'd0;
        got_addr.delete(); got_data.delete();
        unstable = 0; rd_pulses = 0; done_cyc = -1; timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (eot_done0) begin
                timed_out = 1'b0; done_cyc = i;
                break;
            end
            if (mem_rd_en0) rd_pulses++;
            if (stalled && (snap_valid0 !== 1'b1 || snap_addr0 !== pa || snap_data0 !== pd)) unstable++;
            SnapReady   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            InstrValid  = 1'($urandom_range(0, 1));
            Instruction = ($urandom_range(0, 1) == 1) ? EBREAK_OPCODE : ECALL_OPCODE;
            stalled = snap_valid0 && !SnapReady;
            pa = snap_addr0; pd = snap_data0;
            if (snap_valid0 && SnapReady) begin
                got_addr.push_back(snap_addr0);
                got_data.push_back(snap_data0);
            end
            step;
        end
        InstrValid = 1'b0; SnapReady = 1'b0;
    endtask

    task automatic test_reset;
        Rst = 1'b1; InstrValid = 1'b1; Instruction = EBREAK_OPCODE; SnapReady = 1'b1;
        step; step;
        checks++; if ({mem_rd_en0, snap_valid0, eot_done0} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {mem_rd_en0, snap_valid0, eot_done0}); end
        checks++; if (mem_rd_addr0 !== 32'd0 || snap_addr0 !== 32'd0 || snap_data0 !== 32'd0) begin
            errors++; $display("FAIL reset_addr_data got %h %h %h exp 0", mem_rd_addr0, snap_addr0, snap_data0); end
        checks++; if (eot_status0 !== 2'd0 || eot_cycles0 !== 32'd0) begin
            errors++; $display("FAIL reset_status got %0d/%0d exp 0/0", eot_status0, eot_cycles0); end
        InstrValid = 1'b0; SnapReady = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic test_ebreak_dump;
        fill_mem;
        do_reset;
        run_idle(20);
        checks++; if (eot_cycles0 !== 32'd20 || mem_rd_en0 !== 1'b0) begin
            errors++; $display("FAIL run_count got %0d rden %b exp 20 0", eot_cycles0, mem_rd_en0); end
        InstrValid = 1'b1; Instruction = EBREAK_OPCODE;
        step;
        InstrValid = 1'b0;
        checks++; if (eot_status0 !== 2'd1 || eot_cycles0 !== 32'd20) begin
            errors++; $display("FAIL ebreak_event got %0d/%0d exp 1/20", eot_status0, eot_cycles0); end
        checks++; if (mem_rd_en0 !== 1'b1 || mem_rd_addr0 !== 32'h1000) begin
            errors++; $display("FAIL ebreak_first_rd got %b %h exp 1 1000", mem_rd_en0, mem_rd_addr0); end
        collect(1'b0);
        checks++; if (timed_out || done_cyc != 12) begin
            errors++; $display("FAIL ebreak_done_latency got %0d exp 12", done_cyc); end
        checks++; if (got_addr.size() != NENT || rd_pulses != NENT) begin
            errors++; $display("FAIL ebreak_entry_count got %0d rd %0d exp %0d", got_addr.size(), rd_pulses, NENT); end
        else for (int i = 0; i < NENT; i++) begin
            checks++; if (got_addr[i] !== 32'h1000 + 32'(4 * i) || got_data[i] !== mem[i]) begin
                errors++; $display("FAIL ebreak_entry%0d got %h:%h exp %h:%h", i, got_addr[i], got_data[i], 32'h1000 + 32'(4 * i), mem[i]); end
        end
    endtask

    task automatic test_after_done;
        for (int i = 0; i < 5; i++) begin
            InstrValid = 1'b1; Instruction = (i % 2 == 0) ? EBREAK_OPCODE : ECALL_OPCODE;
            step;
            checks++; if (eot_done0 !== 1'b1 || snap_valid0 !== 1'b0 || mem_rd_en0 !== 1'b0
                          || eot_status0 !== 2'd1 || eot_cycles0 !== 32'd20) begin
                errors++; $display("FAIL done_frozen%0d got done %b sv %b rd %b st %0d cyc %0d exp 1 0 0 1 20",
                                   i, eot_done0, snap_valid0, mem_rd_en0, eot_status0, eot_cycles0); end
        end
        InstrValid = 1'b0;
    endtask

    task automatic test_ecall;
        fill_mem;
        do_reset;
        run_idle(10);
        InstrValid = 1'b1; Instruction = ECALL_OPCODE;
        step;
        InstrValid = 1'b0;
        checks++; if (eot_status0 !== 2'd2 || eot_cycles0 !== 32'd10 || mem_rd_en0 !== 1'b1) begin
            errors++; $display("FAIL ecall_en1 got %0d/%0d rd %b exp 2/10 1", eot_status0, eot_cycles0, mem_rd_en0); end
        checks++; if (eot_status1 !== 2'd0 || eot_cycles1 !== 32'd11 || mem_rd_en1 !== 1'b0) begin
            errors++; $display("FAIL ecall_en0 got %0d/%0d rd %b exp 0/11 0", eot_status1, eot_cycles1, mem_rd_en1); end
        for (int i = 0; i < 39; i++) step;
        checks++; if (eot_status1 !== 2'd3 || eot_cycles1 !== 32'd49 || mem_rd_en1 !== 1'b1) begin
            errors++; $display("FAIL ecall_en0_timeout got %0d/%0d rd %b exp 3/49 1", eot_status1, eot_cycles1, mem_rd_en1); end
        checks++; if (snap_valid0 !== 1'b1 || snap_addr0 !== 32'h1000 || snap_data0 !== mem[0]) begin
            errors++; $display("FAIL ecall_stall_hold got %b %h:%h exp 1 1000:%h", snap_valid0, snap_addr0, snap_data0, mem[0]); end
    endtask

    task automatic test_timeout;
        fill_mem;
        do_reset;
        run_idle(49);
        checks++; if (mem_rd_en0 !== 1'b0 || eot_status0 !== 2'd0 || eot_cycles0 !== 32'd49) begin
            errors++; $display("FAIL pre_timeout got rd %b st %0d cyc %0d exp 0 0 49", mem_rd_en0, eot_status0, eot_cycles0); end
        step;
        checks++; if (mem_rd_en0 !== 1'b1 || eot_status0 !== 2'd3 || eot_cycles0 !== 32'd49) begin
            errors++; $display("FAIL timeout_event got rd %b st %0d cyc %0d exp 1 3 49", mem_rd_en0, eot_status0, eot_cycles0); end
        collect(1'b1);
        checks++; if (timed_out || unstable != 0 || rd_pulses != NENT || got_addr.size() != NENT) begin
            errors++; $display("FAIL stall_dump got to %b unstable %0d rd %0d n %0d exp 0 0 %0d %0d",
                               timed_out, unstable, rd_pulses, got_addr.size(), NENT, NENT); end
        else for (int i = 0; i < NENT; i++) begin
            checks++; if (got_addr[i] !== 32'h1000 + 32'(4 * i) || got_data[i] !== mem[i]) begin
                errors++; $display("FAIL stall_entry%0d got %h:%h exp %h:%h", i, got_addr[i], got_data[i], 32'h1000 + 32'(4 * i), mem[i]); end
        end
    endtask

    task automatic test_ebreak_on_timeout;
        fill_mem;
        do_reset;
        run_idle(49);
        InstrValid = 1'b1; Instruction = EBREAK_OPCODE;
        step;
        InstrValid = 1'b0;
        checks++; if (eot_status0 !== 2'd1 || eot_cycles0 !== 32'd49 || eot_status1 !== 2'd1) begin
            errors++; $display("FAIL ebreak_vs_timeout got %0d/%0d dut1 %0d exp 1/49 1", eot_status0, eot_cycles0, eot_status1); end
        collect(1'b0);
        checks++; if (timed_out || done_cyc != 12 || got_data.size() != NENT) begin
            errors++; $display("FAIL ebreak_vs_timeout_dump got cyc %0d n %0d exp 12 %0d", done_cyc, got_data.size(), NENT); end
    endtask

    task automatic test_random;
        bit          v [60];
        logic [31:0] ins [60];
        int          ev, exp_st, r;
        for (int t = 0; t < 6; t++) begin
            fill_mem;
            for (int c = 0; c < 60; c++) begin
                r = int'($urandom_range(0, 99));
                v[c] = ($urandom_range(0, 1) == 1);
                ins[c] = $urandom | 32'h8000_0000;
                if (r < 2)       begin v[c] = 1'b1; ins[c] = EBREAK_OPCODE; end
                else if (r < 4)  begin v[c] = 1'b1; ins[c] = ECALL_OPCODE;  end
                else if (r < 20) begin v[c] = 1'b0; ins[c] = (r % 2 == 0) ? EBREAK_OPCODE : ECALL_OPCODE; end
            end
            // Find the first end event from the rules: ebreak, then ecall, then timeout.
            ev = TO - 1; exp_st = 3;
            for (int c = 0; c < TO; c++) begin
                if (v[c] && ins[c] == EBREAK_OPCODE)     begin ev = c; exp_st = 1; break; end
                else if (v[c] && ins[c] == ECALL_OPCODE) begin ev = c; exp_st = 2; break; end
            end
            do_reset;
            for (int c = 0; c <= ev; c++) begin
                InstrValid = v[c]; Instruction = ins[c];
                step;
            end
            InstrValid = 1'b0;
            checks++; if (eot_status0 !== 2'(exp_st) || eot_cycles0 !== 32'(ev)) begin
                errors++; $display("FAIL rand%0d_event got %0d/%0d exp %0d/%0d", t, eot_status0, eot_cycles0, exp_st, ev); end
            collect(1'b1);
            checks++; if (timed_out || unstable != 0 || got_addr.size() != NENT) begin
                errors++; $display("FAIL rand%0d_dump got to %b unstable %0d n %0d exp 0 0 %0d", t, timed_out, unstable, got_addr.size(), NENT); end
            else for (int i = 0; i < NENT; i++) begin
                checks++; if (got_addr[i] !== 32'h1000 + 32'(4 * i) || got_data[i] !== mem[i]) begin
                    errors++; $display("FAIL rand%0d_entry%0d got %h:%h exp %h:%h", t, i, got_addr[i], got_data[i], 32'h1000 + 32'(4 * i), mem[i]); end
            end
            checks++; if (eot_status0 !== 2'(exp_st) || eot_cycles0 !== 32'(ev)) begin
                errors++; $display("FAIL rand%0d_frozen got %0d/%0d exp %0d/%0d", t, eot_status0, eot_cycles0, exp_st, ev); end
        end
    endtask

    task automatic test_reset_mid_dump;
        bit found;
        fill_mem;
        do_reset;
        run_idle(5);
        InstrValid = 1'b1; Instruction = EBREAK_OPCODE;
        step;
        InstrValid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (snap_valid0 && snap_addr0 == 32'h1008) begin
                SnapReady = 1'b0; found = 1'b1;
                break;
            end
            SnapReady = 1'b1;
            step;
        end
        checks++; if (!found) begin
            errors++; $display("FAIL mid_dump_reach got none exp entry 1008"); end
        Rst = 1'b1;
        step;
        checks++; if ({mem_rd_en0, snap_valid0, eot_done0} !== 3'b000 || mem_rd_addr0 !== 32'd0
                      || snap_addr0 !== 32'd0 || snap_data0 !== 32'd0 || eot_status0 !== 2'd0 || eot_cycles0 !== 32'd0) begin
            errors++; $display("FAIL mid_dump_reset got rd %b sv %b dn %b %h %h %h st %0d cyc %0d exp all 0",
                               mem_rd_en0, snap_valid0, eot_done0, mem_rd_addr0, snap_addr0, snap_data0, eot_status0, eot_cycles0); end
        Rst = 1'b0;
        fill_mem;
        run_idle(7);
        InstrValid = 1'b1; Instruction = EBREAK_OPCODE;
        step;
        InstrValid = 1'b0;
        checks++; if (eot_status0 !== 2'd1 || eot_cycles0 !== 32'd7) begin
            errors++; $display("FAIL rerun_event got %0d/%0d exp 1/7", eot_status0, eot_cycles0); end
        collect(1'b0);
        checks++; if (timed_out || done_cyc != 12 || got_addr.size() != NENT) begin
            errors++; $display("FAIL rerun_dump got cyc %0d n %0d exp 12 %0d", done_cyc, got_addr.size(), NENT); end
        else for (int i = 0; i < NENT; i++) begin
            checks++; if (got_addr[i] !== 32'h1000 + 32'(4 * i) || got_data[i] !== mem[i]) begin
                errors++; $display("FAIL rerun_entry%0d got %h:%h exp %h:%h", i, got_addr[i], got_data[i], 32'h1000 + 32'(4 * i), mem[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_ebreak_dump;
        test_after_done;
        test_ecall;
        test_timeout;
        test_ebreak_on_timeout;
        test_random;
        test_reset_mid_dump;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvc_asap_eot_monitor.md
RVC_ASAP_EOT_MONITOR -- requirements
Module: rvc_asap_eot_monitor

Interface
REQ-001 Parameter D_MEM_OFFSET, 'h1000, byte base address of the dumped data-memory window.
REQ-002 Parameter MSB_D_MEM, 11, window size is 2**(MSB_D_MEM+1) bytes; dump walks 32-bit words.
REQ-003 Parameter TIMEOUT_CYCLES, 1000000, run cycles before forced end-of-test; 0 disables timeout.
REQ-004 Parameter ECALL_EN, 1, when 1 ecall (32'h00000073) also ends the test.
REQ-005 Clock  in  1  single clock; all logic on posedge.
REQ-006 Rst  in  1  synchronous, active-high reset.
REQ-007 InstrValid  in  1  Instruction is a retiring instruction this cycle.
REQ-008 Instruction  in  32  instruction word from the core.
REQ-009 MemRdEn  out  1  data-memory read request.
REQ-010 MemRdAddr  out  32  byte address of read, word aligned.
REQ-011 MemRdData  in  32  read data, valid exactly one cycle after MemRdEn.
REQ-012 SnapValid / SnapReady  out / in  1 / 1  snapshot stream handshake.
REQ-013 SnapAddr / SnapData  out  32 / 32  address and word of current snapshot entry.
REQ-014 EotDone  out  1  dump finished; sticky until Rst.
REQ-015 EotStatus  out  2  end cause: 0 NONE, 1 EBREAK, 2 ECALL, 3 TIMEOUT.
REQ-016 EotCycles  out  32  cycles from reset release to end event, frozen at the event.

Function
REQ-017 FSM states RUN, RD, WAIT, OUT, DONE; Rst forces RUN.
REQ-018 RUN: EotCycles increments each cycle, saturating at 32'hFFFFFFFF.
REQ-019 RUN: InstrValid and Instruction==32'h00100073 -> RD, EotStatus=EBREAK, dump pointer=D_MEM_OFFSET.
REQ-020 RUN: ECALL_EN and InstrValid and Instruction==32'h00000073 -> RD, EotStatus=ECALL.
REQ-021 RUN: TIMEOUT_CYCLES!=0 and EotCycles==TIMEOUT_CYCLES-1 -> RD, EotStatus=TIMEOUT.
REQ-022 Same-cycle priority: EBREAK over ECALL over TIMEOUT; Instruction ignored when InstrValid=0.
REQ-023 RD: MemRdEn=1 for exactly one cycle, MemRdAddr=pointer; -> WAIT.
REQ-024 WAIT: capture MemRdData into SnapData, SnapAddr=pointer; -> OUT.
REQ-025 OUT: SnapValid=1; SnapAddr/SnapData held stable until SnapValid&&SnapReady.
REQ-026 OUT handshake: pointer==D_MEM_OFFSET+2**(MSB_D_MEM+1)-4 -> DONE, else pointer+=4 -> RD.
REQ-027 DONE: EotDone=1, SnapValid=0, MemRdEn=0; Instruction ignored; EotStatus/EotCycles frozen.
REQ-028 Per-entry cost is 3 cycles with SnapReady held high; full dump = 3*2**(MSB_D_MEM-1) cycles.
REQ-029 Pointer arithmetic is 32-bit; no wrap occurs within the window.
REQ-030 After the end event, EotCycles no longer counts and further ebreak/ecall are ignored.

Reset
REQ-031 Rst in any state (incl. mid-dump with SnapValid=1) returns to RUN next cycle, drops SnapValid with no handshake.
REQ-032 Reset values: MemRdEn=0, MemRdAddr=0, SnapValid=0, SnapAddr=0, SnapData=0, EotDone=0, EotStatus=NONE, EotCycles=0.

Structure
REQ-033 rvc_asap_pkg holds eot_status_t enum, eot_state_t enum, EBREAK_OPCODE and ECALL_OPCODE constants.
REQ-034 No sub-module; counter, pointer and FSM are inline, all registers via the codebase flop macros.

Verification
REQ-035 Ebreak at cycle 20 after reset, SnapReady=1, MSB_D_MEM=3 -> 4 entries at 'h1000..'h100C match memory, EotStatus=1, EotCycles=20, EotDone after 12 cycles.
REQ-036 Ecall with ECALL_EN=0 -> no end event; same with ECALL_EN=1 -> EotStatus=2.
REQ-037 TIMEOUT_CYCLES=50, no ebreak -> dump starts at cycle 50, EotStatus=3, EotCycles=49.
REQ-038 Ebreak, InstrValid=1, on the exact timeout cycle -> EotStatus=1.
REQ-039 SnapReady toggled randomly during dump -> SnapAddr/SnapData stable while stalled, no entry lost or duplicated.
REQ-040 Rst asserted during OUT of entry 2 -> all outputs at reset values next cycle, fresh run completes normally.
